// File: rtl/alu_issue_stage.sv
// Two-stage execute front-end for LC-3b operate instructions.
// Stage 1 decodes and registers the ALU operands. An external combinational
// ALU computes the result from those registers. Stage 2 captures that result
// with its condition codes and offers it as a writeback packet. The packet
// uses valid/ready backpressure.
module alu_issue_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_IR,
  input  logic [WIDTH-1:0] IN_SR1,
  input  logic [WIDTH-1:0] IN_SR2,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic [1:0]       ALU_OP,
  input  logic [WIDTH-1:0] ALU_RESULT,
  output logic             WB_VALID,
  input  logic             WB_READY,
  output logic [2:0]       WB_DR,
  output logic [WIDTH-1:0] WB_DATA,
  output logic [2:0]       WB_NZP,
  output logic             ERR,
  output logic [CNT_W-1:0] RETIRED
);

  localparam logic [3:0] OPC_ADD = 4'b0001;
  localparam logic [3:0] OPC_AND = 4'b0101;
  localparam logic [3:0] OPC_XOR = 4'b1001;
  localparam logic [3:0] OPC_SHF = 4'b1101;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_AND   = 2'b01;
  localparam logic [1:0] OP_XOR   = 2'b10;
  localparam logic [1:0] OP_PASSA = 2'b11;

  logic             s1_valid;
  logic             s2_valid;
  logic [2:0]       s1_dr;
  logic             s1_adv;
  logic             s2_adv;
  logic             accept;
  logic             legal;
  logic [WIDTH-1:0] dec_a;
  logic [WIDTH-1:0] dec_b;
  logic [1:0]       dec_op;
  logic [WIDTH-1:0] imm5;
  logic [WIDTH-1:0] opnd2;
  logic [WIDTH-1:0] shf;
  logic [3:0]       amt;
  logic             wb_fire;

  // The SR1 register index is resolved upstream. Only its value arrives here.
  wire unused_sr1_sel = ^IN_IR[8:6];

  assign s2_adv   = !s2_valid || WB_READY;
  assign s1_adv   = !s1_valid || s2_adv;
  assign IN_READY = s1_adv;
  assign accept   = IN_VALID && s1_adv;
  assign WB_VALID = s2_valid;
  assign wb_fire  = s2_valid && WB_READY;

  assign imm5  = {{(WIDTH-5){IN_IR[4]}}, IN_IR[4:0]};
  assign opnd2 = IN_IR[5] ? imm5 : IN_SR2;
  assign amt   = IN_IR[3:0];

  // Shifter for SHF. IR[4]=0 is LSHF regardless of IR[5].
  always_comb begin
    shf = IN_SR1 << amt;
    if (IN_IR[4]) begin
      if (IN_IR[5]) shf = WIDTH'($signed(IN_SR1) >>> amt);
      else          shf = IN_SR1 >> amt;
    end
  end

  // Opcode decode into ALU operands and op select.
  always_comb begin
    legal  = 1'b1;
    dec_a  = IN_SR1;
    dec_b  = opnd2;
    dec_op = OP_ADD;
    case (IN_IR[15:12])
      OPC_ADD: dec_op = OP_ADD;
      OPC_AND: dec_op = OP_AND;
      OPC_XOR: dec_op = OP_XOR;
      OPC_SHF: begin
        dec_a  = shf;
        dec_b  = '0;
        dec_op = OP_PASSA;
      end
      default: legal = 1'b0;
    endcase
  end

  // Stage 1: operand registers. An illegal opcode is consumed as a bubble.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_valid <= 1'b0;
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_OP   <= OP_ADD;
      s1_dr    <= '0;
    end else if (s1_adv) begin
      s1_valid <= IN_VALID && legal;
      if (IN_VALID) begin
        ALU_A  <= dec_a;
        ALU_B  <= dec_b;
        ALU_OP <= dec_op;
        s1_dr  <= IN_IR[11:9];
      end
    end
  end

  // Stage 2: capture the ALU result and its condition codes.
  // The packet fields hold their values while the stage is empty.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      s2_valid <= 1'b0;
      WB_DR    <= '0;
      WB_DATA  <= '0;
      WB_NZP   <= 3'b010;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        WB_DATA <= ALU_RESULT;
        WB_DR   <= s1_dr;
        if (ALU_RESULT[WIDTH-1]) WB_NZP <= 3'b100;
        else if (ALU_RESULT == '0) WB_NZP <= 3'b010;
        else WB_NZP <= 3'b001;
      end
    end
  end

  // Sticky illegal-opcode flag and the retired-instruction counter.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ERR     <= 1'b0;
      RETIRED <= '0;
    end else begin
      if (accept && !legal) ERR <= 1'b1;
      if (wb_fire) RETIRED <= RETIRED + 1'b1;
    end
  end

endmodule
